// File: rtl/unidade_controle.sv
`default_nettype none
// ============================================================================
// Module   : unidade_controle
// Purpose  : Control unit of the multicycle processor datapath. Fetches an
//            instruction word from din into an internal IR, steps it through
//            T0-T3 and decodes (tstep, IR) into the bus-multiplexer selector,
//            register/A/G load enables, ALU operation and done.
// Ports    : clock   - system clock, rising edge active
//            reset   - asynchronous active-high reset (returns to idle T0)
//            run     - start request, sampled only in T0
//            din     - instruction word, latched into IR at end of T0
//            mux_sel - bus selector: 0-7 Rn, 8 DIN, 9 G, 10 const 0, 11 const 1
//            r_in    - one-hot load enables for R0-R7
//            a_in    - load enable for ALU operand register A
//            g_in    - load enable for ALU result register G
//            ir_in   - IR load strobe (run while in T0)
//            alu_op  - 0 ADD, 1 SUB, 2 AND
//            done    - high in the last step of every instruction
//            tstep   - current step, for debug
// Revision : 1.0 - initial release
// ============================================================================
module unidade_controle #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  run,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [3:0]            mux_sel,
    output logic [7:0]            r_in,
    output logic                  a_in,
    output logic                  g_in,
    output logic                  ir_in,
    output logic [1:0]            alu_op,
    output logic                  done,
    output logic [1:0]            tstep
);

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } step_t;

    // Bus selector codes shared with the multiplexer
    localparam logic [3:0] c_SEL_DIN  = 4'd8;
    localparam logic [3:0] c_SEL_G    = 4'd9;
    localparam logic [3:0] c_SEL_ZERO = 4'd10;
    localparam logic [3:0] c_SEL_ONE  = 4'd11;

    localparam logic [1:0] c_ALU_ADD = 2'd0;
    localparam logic [1:0] c_ALU_SUB = 2'd1;
    localparam logic [1:0] c_ALU_AND = 2'd2;

    localparam logic [3:0] c_OP_MV  = 4'd0;
    localparam logic [3:0] c_OP_MVI = 4'd1;
    localparam logic [3:0] c_OP_ADD = 4'd2;
    localparam logic [3:0] c_OP_SUB = 4'd3;
    localparam logic [3:0] c_OP_AND = 4'd4;
    localparam logic [3:0] c_OP_CLR = 4'd5;
    localparam logic [3:0] c_OP_INC = 4'd6;
    localparam logic [3:0] c_OP_DEC = 4'd7;

    step_t                 r_step;
    logic [DATA_WIDTH-1:0] r_ir;

    logic [3:0] w_opcode;
    logic [2:0] w_x;
    logic [2:0] w_y;
    logic [7:0] w_x_onehot;
    logic       w_unused_ir;

    assign w_opcode    = r_ir[15:12];
    assign w_x         = r_ir[11:9];
    assign w_y         = r_ir[8:6];
    assign w_x_onehot  = 8'd1 << w_x;
    // Low IR bits (and any bits above 15) carry no control information
    assign w_unused_ir = ^r_ir;

    // ------------------------------------------------------------------
    // Step sequencing and instruction fetch
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_step <= T0;
            r_ir   <= '0;
        end else begin
            case (r_step)
                T0: begin
                    if (run) begin
                        r_ir   <= din;
                        r_step <= T1;
                    end
                end
                default: begin
                    if (done) r_step <= T0;
                    else      r_step <= step_t'(r_step + 2'd1);
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output decode: purely a function of the registered step and IR, so
    // outputs only move after a clock edge (or an async reset).
    // ------------------------------------------------------------------
    always_comb begin
        mux_sel = c_SEL_ZERO;
        r_in    = 8'd0;
        a_in    = 1'b0;
        g_in    = 1'b0;
        alu_op  = c_ALU_ADD;
        done    = 1'b0;

        if (r_step != T0) begin
            case (w_opcode)
                c_OP_MV: begin
                    mux_sel = {1'b0, w_y};
                    r_in    = w_x_onehot;
                    done    = 1'b1;
                end
                c_OP_MVI: begin
                    mux_sel = c_SEL_DIN;
                    r_in    = w_x_onehot;
                    done    = 1'b1;
                end
                c_OP_CLR: begin
                    mux_sel = c_SEL_ZERO;
                    r_in    = w_x_onehot;
                    done    = 1'b1;
                end
                c_OP_ADD, c_OP_SUB, c_OP_AND, c_OP_INC, c_OP_DEC: begin
                    case (r_step)
                        T1: begin
                            mux_sel = {1'b0, w_x};
                            a_in    = 1'b1;
                        end
                        T2: begin
                            // inc/dec use constant 1 as the second operand
                            if (w_opcode == c_OP_INC || w_opcode == c_OP_DEC)
                                mux_sel = c_SEL_ONE;
                            else
                                mux_sel = {1'b0, w_y};
                            g_in = 1'b1;
                            if (w_opcode == c_OP_SUB || w_opcode == c_OP_DEC)
                                alu_op = c_ALU_SUB;
                            else if (w_opcode == c_OP_AND)
                                alu_op = c_ALU_AND;
                            else
                                alu_op = c_ALU_ADD;
                        end
                        default: begin
                            mux_sel = c_SEL_G;
                            r_in    = w_x_onehot;
                            done    = 1'b1;
                        end
                    endcase
                end
                default: begin
                    // Illegal opcode: two-cycle NOP
                    done = 1'b1;
                end
            endcase
        end
    end

    // Gated by reset so no strobe survives reset being applied
    assign ir_in = run & (r_step == T0) & ~reset;
    assign tstep = r_step;

endmodule
`default_nettype wire

// File: doc/unidade_controle.md
Name: unidade_controle

Overview:
- Control unit of the multicycle processor datapath.
- Sits directly upstream of the bus multiplexer and drives its 4-bit selector, using the same encoding: 0-7 = R0-R7, 8 = DIN, 9 = G, 10 = constant 0, 11 = constant 1.
- Latches each instruction from DIN into an internal IR and steps it through T0-T3.
- Generates the register, A, G and IR load enables, the ALU operation and done.

Parameters:
- DATA_WIDTH, 16, width of din and of the internal IR.

Ports:
- clock  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high; forces the idle state.
- run  input  1  start request; sampled only in T0.
- din  input  DATA_WIDTH  instruction word; latched into IR at the end of T0.
- mux_sel  output  4  bus multiplexer selector (encoding above).
- r_in  output  8  one-hot load enables for R0-R7.
- a_in  output  1  load enable for ALU operand register A.
- g_in  output  1  load enable for ALU result register G.
- ir_in  output  1  IR load strobe; exported so DIN sourcing logic can align to it.
- alu_op  output  2  ALU operation: 0 = ADD, 1 = SUB, 2 = AND.
- done  output  1  high in the last step of every instruction.
- tstep  output  2  current step (0-3), for debug.

Behaviour:
- Reset (async, active-high): tstep = 0 and IR = 0. While idle: mux_sel = 10, r_in = 0, a_in = g_in = 0, alu_op = 0, done = 0.
- Reset mid-instruction aborts the instruction immediately. No enable may stay asserted after reset is applied.
- IR fields: opcode = IR[15:12], X = IR[11:9], Y = IR[8:6]. IR[5:0] are ignored.
- All outputs are combinational from (tstep, IR) and are glitch-free relative to clock.
- Exception: ir_in = run while in T0.

Step sequencing:
- T0: if run = 1, IR <= din and next step is T1. Otherwise stay in T0.
- Any step with done = 1 returns to T0 on the next edge. Otherwise tstep increments.
- run is ignored outside T0.
- A new instruction can start on the edge after done. If run is held high, instructions issue back-to-back with no idle cycle other than the T0 fetch.

Instruction steps (unlisted outputs are 0 / default):
- 0 mv X,Y: T1 mux_sel = Y, r_in[X] = 1, done.
- 1 mvi X: T1 mux_sel = 8, r_in[X] = 1, done. The immediate is on DIN during T1.
- 2 add X,Y:
  - T1 mux_sel = X, a_in.
  - T2 mux_sel = Y, g_in, alu_op = 0.
  - T3 mux_sel = 9, r_in[X], done.
- 3 sub: as add with alu_op = 1 in T2.
- 4 and: as add with alu_op = 2 in T2.
- 5 clr X: T1 mux_sel = 10, r_in[X], done.
- 6 inc X:
  - T1 mux_sel = X, a_in.
  - T2 mux_sel = 11, g_in, alu_op = 0.
  - T3 mux_sel = 9, r_in[X], done.
- 7 dec X: as inc with alu_op = 1 in T2.
- 8-15 illegal: T1 done only, with no load enables (NOP, 2 cycles).

Invariants:
- At most one bit of r_in is set at any time.
- a_in and g_in are never asserted in the same cycle.
- mux_sel never exceeds 11.
- X = Y (e.g. add R3,R3) is legal and needs no special handling.

Test Plan:
- Reset held, then released with run = 0 for 5 cycles -> tstep = 0, mux_sel = 10, r_in = 0, done = 0 throughout.
- run = 1, din = 0x1A00 (mvi R5), then din = 0x00FF in the next cycle:
  - ir_in is high in T0.
  - Next cycle: mux_sel = 8, r_in = 0x20, done = 1.
  - Following cycle: tstep = 0.
- din = 0x2440 (add R2,R1), run pulse -> per-cycle outputs:
  - T1: mux_sel = 2, a_in.
  - T2: mux_sel = 1, g_in, alu_op = 0.
  - T3: mux_sel = 9, r_in = 0x04, done.
- din = 0x6E00 (inc R7), then din = 0x7E00 (dec R7), with run held high:
  - inc: T2 mux_sel = 11, alu_op = 0.
  - dec: T2 mux_sel = 11, alu_op = 1.
  - Second fetch occurs in the cycle right after the first done.
- din = 0xF000 (illegal) -> T1 done = 1 with r_in = 0 and a_in = g_in = 0. Back in T0 next cycle.
- Assert reset asynchronously in T2 of a sub -> g_in drops immediately, tstep = 0, no r_in pulse occurs. After release, a new mv issues normally.
